vga_sync_decoder: RTL



---
 rtl/vga_timing_pkg.sv | 37 +++
 rtl/sync_edge_detect.sv | 34 +++
 rtl/vga_sync_decoder.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared timing constants and types for the VGA receive path.
//
// Contents:
//   VGA_* constants  - 640x480 line/frame geometry in pixel clocks / lines
//   VGA_H_TOTAL      - derived line length (800 clocks)
//   VGA_V_TOTAL      - derived frame length (525 lines)
//   CNT_W / CNT_MAX  - width and saturation value of the h/v counters
//   lock_state_t     - lock FSM states
//   sat_inc()        - saturating increment used by both counters
package vga_timing_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FRONT  = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BACK   = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FRONT  = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BACK   = 33;

    localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
    localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    localparam int              CNT_W   = 11;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } lock_state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Registers one sync input, normalises it to active-high and flags the
// clock on which it first becomes asserted.
//
// Ports:
//   iCLK  - pixel clock
//   iRST  - synchronous active-high reset (internal sync reads deasserted)
//   iSync - raw sync pin, asserted level given by SYNC_POL
//   oEdge - one-cycle pulse on the first registered asserted clock
module sync_edge_detect #(
    parameter bit SYNC_POL = 1'b0
) (
    input  logic iCLK,
    input  logic iRST,
    input  logic iSync,
    output logic oEdge
);

    logic active_q;
    logic active_prev_q;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            active_q      <= 1'b0;
            active_prev_q <= 1'b0;
        end else begin
            // XOR with the inverse of the asserted level gives active-high.
            active_q      <= iSync ^ ~SYNC_POL;
            active_prev_q <= active_q;
        end
    end

    assign oEdge = active_q & ~active_prev_q;

endmodule

// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing decoder. Recovers pixel coordinates from an
// HS/VS/RGB stream, measures line and frame lengths and declares lock once
// LOCK_FRAMES consecutive frames match the configured geometry.
//
// Ports:
//   iCLK, iRST              - pixel clock, synchronous active-high reset
//   iHS, iVS                - syncs, asserted level given by SYNC_POL
//   iRed/iGreen/iBlue       - pixel colour
//   oX, oY                  - recovered active column/row (held when !oValid)
//   oValid                  - active pixel while locked
//   oRed/oGreen/oBlue       - colour aligned to oX/oY, zero when !oValid
//   oFrameStart             - pulse with pixel (0,0)
//   oLocked                 - timing lock indicator
//   oH_TOTAL, oV_TOTAL      - last measured line (clocks) / frame (lines)
//   oLockState              - lock FSM state for observation
// All data outputs appear 2 clocks after the corresponding input pins.
module vga_sync_decoder
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE    = VGA_H_ACTIVE,
    parameter int H_FRONT     = VGA_H_FRONT,
    parameter int H_SYNC      = VGA_H_SYNC,
    parameter int H_BACK      = VGA_H_BACK,
    parameter int V_ACTIVE    = VGA_V_ACTIVE,
    parameter int V_FRONT     = VGA_V_FRONT,
    parameter int V_SYNC      = VGA_V_SYNC,
    parameter int V_BACK      = VGA_V_BACK,
    parameter bit SYNC_POL    = 1'b0,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iHS,
    input  logic        iVS,
    input  logic [9:0]  iRed,
    input  logic [9:0]  iGreen,
    input  logic [9:0]  iBlue,
    output logic [9:0]  oX,
    output logic [9:0]  oY,
    output logic        oValid,
    output logic [9:0]  oRed,
    output logic [9:0]  oGreen,
    output logic [9:0]  oBlue,
    output logic        oFrameStart,
    output logic        oLocked,
    output logic [10:0] oH_TOTAL,
    output logic [10:0] oV_TOTAL,
    output logic [1:0]  oLockState
);

    localparam logic [CNT_W-1:0] LINE_LEN  = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK);
    localparam logic [CNT_W-1:0] FRAME_LEN = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK);
    localparam logic [CNT_W-1:0] X_OFS     = CNT_W'(H_SYNC + H_BACK);
    localparam logic [CNT_W-1:0] Y_OFS     = CNT_W'(V_SYNC + V_BACK);
    localparam logic [CNT_W-1:0] X_LIM     = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] Y_LIM     = CNT_W'(V_ACTIVE);
    localparam logic [2:0]       GOOD_TGT  = 3'(LOCK_FRAMES);

    // Stage 1: registered syncs (inside the edge detectors) and colour.
    logic       hs_edge;
    logic       vs_edge;
    logic [9:0] red_q, green_q, blue_q;

    sync_edge_detect #(.SYNC_POL(SYNC_POL)) u_hs_edge (
        .iCLK  (iCLK),
        .iRST  (iRST),
        .iSync (iHS),
        .oEdge (hs_edge)
    );

    sync_edge_detect #(.SYNC_POL(SYNC_POL)) u_vs_edge (
        .iCLK  (iCLK),
        .iRST  (iRST),
        .iSync (iVS),
        .oEdge (vs_edge)
    );

    // Stage 2 state.
    logic [CNT_W-1:0] hcnt_q, vcnt_q;
    logic             h_seen_q;     // a previous HS edge exists to measure from
    logic             line_err_q;   // a mis-sized line occurred this frame
    logic [2:0]       good_cnt_q;
    lock_state_t      state_q;

    // Counter values belonging to the pixel currently in stage 1.
    logic [CNT_W-1:0] hcnt_n, vcnt_n;
    logic [CNT_W-1:0] h_meas, v_meas;
    logic [CNT_W-1:0] x_pos, y_pos;
    logic             sat_hit;
    logic             line_bad;
    logic             frame_good;
    logic             active;

    always_comb begin
        hcnt_n = hs_edge ? '0 : sat_inc(hcnt_q);

        // VS wins over a coincident HS edge.
        vcnt_n = vcnt_q;
        if (vs_edge) begin
            vcnt_n = '0;
        end else if (hs_edge) begin
            vcnt_n = sat_inc(vcnt_q);
        end

        sat_hit = (hcnt_n == CNT_MAX) || (vcnt_n == CNT_MAX);

        // Measured lengths clamp rather than wrap once a counter saturated.
        h_meas = (hcnt_q == CNT_MAX) ? CNT_MAX : hcnt_q + 1'b1;
        v_meas = (vcnt_q == CNT_MAX) ? CNT_MAX : vcnt_q + 1'b1;

        line_bad   = hs_edge && h_seen_q && (h_meas != LINE_LEN);
        // The line closed by a coincident HS edge still belongs to the
        // frame ending here, so its error is folded in directly.
        frame_good = !line_err_q && !line_bad && (v_meas == FRAME_LEN);

        x_pos  = hcnt_n - X_OFS;
        y_pos  = vcnt_n - Y_OFS;
        active = ($signed(x_pos) >= 0) && ($signed(x_pos) < $signed(X_LIM)) &&
                 ($signed(y_pos) >= 0) && ($signed(y_pos) < $signed(Y_LIM));
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            red_q       <= '0;
            green_q     <= '0;
            blue_q      <= '0;
            hcnt_q      <= '0;
            vcnt_q      <= '0;
            h_seen_q    <= 1'b0;
            line_err_q  <= 1'b0;
            good_cnt_q  <= '0;
            state_q     <= SEARCH;
            oLocked     <= 1'b0;
            oX          <= '0;
            oY          <= '0;
            oValid      <= 1'b0;
            oRed        <= '0;
            oGreen      <= '0;
            oBlue       <= '0;
            oFrameStart <= 1'b0;
            oH_TOTAL    <= '0;
            oV_TOTAL    <= '0;
        end else begin
            red_q   <= iRed;
            green_q <= iGreen;
            blue_q  <= iBlue;

            hcnt_q <= hcnt_n;
            vcnt_q <= vcnt_n;

            if (hs_edge) oH_TOTAL <= h_meas;
            if (vs_edge) oV_TOTAL <= v_meas;

            // After saturation the next HS edge has no valid reference.
            if (hcnt_n == CNT_MAX) begin
                h_seen_q <= 1'b0;
            end else if (hs_edge) begin
                h_seen_q <= 1'b1;
            end

            if (vs_edge) begin
                line_err_q <= 1'b0;
            end else if (line_bad) begin
                line_err_q <= 1'b1;
            end

            // Lock FSM; oLocked is updated together with every state change.
            if (sat_hit) begin
                state_q    <= SEARCH;
                good_cnt_q <= '0;
                oLocked    <= 1'b0;
            end else if (vs_edge) begin
                case (state_q)
                    SEARCH: begin
                        state_q    <= ACQUIRE;
                        good_cnt_q <= '0;
                        oLocked    <= 1'b0;
                    end
                    ACQUIRE: begin
                        if (frame_good) begin
                            good_cnt_q <= good_cnt_q + 3'd1;
                            if (good_cnt_q + 3'd1 == GOOD_TGT) begin
                                state_q <= LOCKED;
                                oLocked <= 1'b1;
                            end
                        end else begin
                            good_cnt_q <= '0;
                        end
                    end
                    LOCKED: begin
                        if (!frame_good) begin
                            state_q    <= ACQUIRE;
                            good_cnt_q <= '0;
                            oLocked    <= 1'b0;
                        end
                    end
                    default: begin
                        state_q    <= SEARCH;
                        good_cnt_q <= '0;
                        oLocked    <= 1'b0;
                    end
                endcase
            end

            if (active && (state_q == LOCKED)) begin
                oValid      <= 1'b1;
                oX          <= x_pos[9:0];
                oY          <= y_pos[9:0];
                oRed        <= red_q;
                oGreen      <= green_q;
                oBlue       <= blue_q;
                oFrameStart <= (x_pos == '0) && (y_pos == '0);
            end else begin
                oValid      <= 1'b0;
                oRed        <= '0;
                oGreen      <= '0;
                oBlue       <= '0;
                oFrameStart <= 1'b0;
            end
        end
    end

    assign oLockState = state_q;

endmodule
